bit_serial_adder: RTL and testbench



---
 rtl/bsa_pkg.sv | 17 +
 rtl/bsa_chunk_add.sv | 23 ++
 rtl/bit_serial_adder.sv | 134 +++++++++++++
 tb/tb_bit_serial_adder.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and a
// helper that sizes the step counter.
package bsa_pkg;

    // Two-bit state encoding kept as plain constants for older consumers.
    typedef logic [1:0] bsa_state_t;

    localparam bsa_state_t StIdle = 2'd0;
    localparam bsa_state_t StBusy = 2'd1;
    localparam bsa_state_t StDone = 2'd2;

    // Step counter width: clog2(steps), never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/bsa_chunk_add.sv
// Combinational ripple of BITS full-adder cells; one chunk per clock step.
module bsa_chunk_add #(
    parameter int unsigned BITS = 1
) (
    input  logic [BITS-1:0] a_chunk,
    input  logic [BITS-1:0] b_chunk,
    input  logic            cin,
    output logic [BITS-1:0] sum_chunk,
    output logic            cout
);

    logic [BITS:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < BITS; i++) begin : g_fa
        assign sum_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ carry[i];
        assign carry[i+1]   = (a_chunk[i] & b_chunk[i]) | (carry[i] & (a_chunk[i] ^ b_chunk[i]));
    end

    assign cout = carry[BITS];

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed BITS_PER_CYCLE bits per clock,
// carry held in a register between steps, valid/ready on both sides.
// Optional macro BSA_SUB_EN adds the sub port (a - b via inverted B at capture).
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef BSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = cnt_width(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    if ((WIDTH == 0) || (BITS_PER_CYCLE == 0) || (WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_cfg
        $error("bit_serial_adder: BITS_PER_CYCLE must be nonzero and divide WIDTH");
    end

    logic sub_eff;
`ifdef BSA_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    bsa_state_t          state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]    acc_q, acc_d, acc_shift;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic                carry_q, carry_d, cout_q, cout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BITS_PER_CYCLE-1:0] chunk_sum;
    logic                chunk_cout;

    bsa_chunk_add #(
        .BITS (BITS_PER_CYCLE)
    ) u_chunk (
        .a_chunk   (a_q[BITS_PER_CYCLE-1:0]),
        .b_chunk   (b_q[BITS_PER_CYCLE-1:0]),
        .cin       (carry_q),
        .sum_chunk (chunk_sum),
        .cout      (chunk_cout)
    );

    // Chunk result enters at the MSB end; after STEPS shifts it sits in place.
    assign acc_shift = (acc_q >> BITS_PER_CYCLE)
                     | (WIDTH'(chunk_sum) << (WIDTH - BITS_PER_CYCLE));

    // Next-state logic: capture in IDLE, one chunk per BUSY cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub_eff ? ~b : b;
                    carry_d = cin ^ sub_eff;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                a_d     = a_q >> BITS_PER_CYCLE;
                b_d     = b_q >> BITS_PER_CYCLE;
                acc_d   = acc_shift;
                carry_d = chunk_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    // Outputs only change when a full result is ready.
                    sum_d   = acc_shift;
                    cout_d  = chunk_cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset also aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: three configurations (8/1, 8/4, 4/4) against
// an arithmetic reference model. Honours BSA_SUB_EN when defined.
module tb_bit_serial_adder;

`ifdef BSA_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT 0: WIDTH=8, BPC=1
    logic       d0_in_valid = 0, d0_in_ready, d0_cin = 0, d0_sub = 0;
    logic [7:0] d0_a = 0, d0_b = 0, d0_sum;
    logic       d0_out_valid, d0_out_ready = 0, d0_cout;
    // DUT 1: WIDTH=8, BPC=4
    logic       d1_in_valid = 0, d1_in_ready, d1_cin = 0, d1_sub = 0;
    logic [7:0] d1_a = 0, d1_b = 0, d1_sum;
    logic       d1_out_valid, d1_out_ready = 0, d1_cout;
    // DUT 2: WIDTH=4, BPC=4
    logic       d2_in_valid = 0, d2_in_ready, d2_cin = 0, d2_sub = 0;
    logic [3:0] d2_a = 0, d2_b = 0, d2_sum;
    logic       d2_out_valid, d2_out_ready = 0, d2_cout;

    bit_serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .a(d0_a), .b(d0_b), .cin(d0_cin),
`ifdef BSA_SUB_EN
        .sub(d0_sub),
`endif
        .out_valid(d0_out_valid), .out_ready(d0_out_ready), .sum(d0_sum), .cout(d0_cout)
    );

    bit_serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .cin(d1_cin),
`ifdef BSA_SUB_EN
        .sub(d1_sub),
`endif
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .sum(d1_sum), .cout(d1_cout)
    );

    bit_serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .a(d2_a), .b(d2_b), .cin(d2_cin),
`ifdef BSA_SUB_EN
        .sub(d2_sub),
`endif
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .sum(d2_sum), .cout(d2_cout)
    );

    // Reference: full (w+1)-bit result of a + b + cin, or a - b style when s=1.
    function automatic int unsigned model(input int unsigned w, input int unsigned a,
                                          input int unsigned b, input bit c, input bit s);
        int unsigned bb;
        bb = s ? (((32'd1 << w) - 1) - b) : b;
        return a + bb + 32'(c ^ s);
    endfunction

    // One transaction on DUT 0; lat counts edges from accept to out_valid.
    task automatic run_d0(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic s, output logic [7:0] rs, output logic rc,
                          output int lat);
        @(negedge clk);
        d0_a = a; d0_b = b; d0_cin = c; d0_sub = s; d0_in_valid = 1'b1;
        @(negedge clk);
        d0_in_valid = 1'b0;
        lat = 0;
        while (!d0_out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        rs = d0_sum; rc = d0_cout;
        d0_out_ready = 1'b1;
        @(negedge clk);
        d0_out_ready = 1'b0;
    endtask

    task automatic run_d1(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic s, output logic [7:0] rs, output logic rc,
                          output int lat);
        @(negedge clk);
        d1_a = a; d1_b = b; d1_cin = c; d1_sub = s; d1_in_valid = 1'b1;
        @(negedge clk);
        d1_in_valid = 1'b0;
        lat = 0;
        while (!d1_out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        rs = d1_sum; rc = d1_cout;
        d1_out_ready = 1'b1;
        @(negedge clk);
        d1_out_ready = 1'b0;
    endtask

    task automatic run_d2(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input logic s, output logic [3:0] rs, output logic rc,
                          output int lat);
        @(negedge clk);
        d2_a = a; d2_b = b; d2_cin = c; d2_sub = s; d2_in_valid = 1'b1;
        @(negedge clk);
        d2_in_valid = 1'b0;
        lat = 0;
        while (!d2_out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        rs = d2_sum; rc = d2_cout;
        d2_out_ready = 1'b1;
        @(negedge clk);
        d2_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({d0_in_ready, d0_out_valid, d0_sum, d0_cout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_d0: rdy=%b vld=%b sum=%h cout=%b, want 1 0 00 0",
                     d0_in_ready, d0_out_valid, d0_sum, d0_cout);
        end
        checks++;
        if ({d1_in_ready, d1_out_valid, d1_sum, d1_cout, d2_in_ready, d2_out_valid, d2_sum,
             d2_cout} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_d1d2: d1 %b %b %h %b d2 %b %b %h %b, want 1 0 0 0 each",
                     d1_in_ready, d1_out_valid, d1_sum, d1_cout,
                     d2_in_ready, d2_out_valid, d2_sum, d2_cout);
        end
    endtask

    task automatic test_directed();
        logic [7:0] rs; logic rc; int lat;
        run_d0(8'hFF, 8'h01, 1'b0, 1'b0, rs, rc, lat);
        checks++;
        if ({rc, rs} !== 9'h100 || lat != 8) begin
            errors++;
            $display("FAIL ff_plus_01: got cout=%b sum=%h lat=%0d, want 1 00 8", rc, rs, lat);
        end
        run_d0(8'h5A, 8'hA5, 1'b1, 1'b0, rs, rc, lat);
        checks++;
        if ({rc, rs} !== 9'h100 || lat != 8) begin
            errors++;
            $display("FAIL 5a_a5_cin: got cout=%b sum=%h lat=%0d, want 1 00 8", rc, rs, lat);
        end
        run_d0(8'h00, 8'h00, 1'b0, 1'b0, rs, rc, lat);
        checks++;
        if ({rc, rs} !== 9'h000 || lat != 8) begin
            errors++;
            $display("FAIL zero_zero: got cout=%b sum=%h lat=%0d, want 0 00 8", rc, rs, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        d0_a = 8'h12; d0_b = 8'h34; d0_cin = 1'b0; d0_sub = 1'b0; d0_in_valid = 1'b1;
        @(negedge clk);
        d0_in_valid = 1'b0;
        lat = 0;
        while (!d0_out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL bp_latency: got %0d, want 8", lat);
        end
        // Offer new operands while holding; they must be ignored.
        d0_a = 8'hFF; d0_b = 8'hFF; d0_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({d0_out_valid, d0_in_ready, d0_sum, d0_cout} !== {1'b1, 1'b0, 8'h46, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b sum=%h cout=%b, want 1 0 46 0",
                         i, d0_out_valid, d0_in_ready, d0_sum, d0_cout);
            end
            @(negedge clk);
        end
        d0_in_valid = 1'b0;
        d0_out_ready = 1'b1;
        @(negedge clk);
        d0_out_ready = 1'b0;
        checks++;
        if ({d0_out_valid, d0_in_ready, d0_sum} !== {1'b0, 1'b1, 8'h46}) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b sum=%h, want 0 1 46",
                     d0_out_valid, d0_in_ready, d0_sum);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] rs; logic rc; int lat; int seen;
        @(negedge clk);
        d0_a = 8'h33; d0_b = 8'h44; d0_cin = 1'b1; d0_sub = 1'b0; d0_in_valid = 1'b1;
        @(negedge clk);                 // first BUSY cycle
        d0_in_valid = 1'b0;
        repeat (2) @(negedge clk);      // third BUSY cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({d0_in_ready, d0_out_valid, d0_sum, d0_cout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b sum=%h cout=%b, want 1 0 00 0",
                     d0_in_ready, d0_out_valid, d0_sum, d0_cout);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d0_out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_no_pulse: out_valid cycles=%0d, want 0", seen);
        end
        run_d0(8'h01, 8'h01, 1'b0, 1'b0, rs, rc, lat);
        checks++;
        if ({rc, rs} !== 9'h002 || lat != 8) begin
            errors++;
            $display("FAIL after_reset_1p1: cout=%b sum=%h lat=%0d, want 0 02 8", rc, rs, lat);
        end
    endtask

    task automatic test_random_d0();
        logic [7:0] a, b, rs; logic c, s, rc; int lat; int unsigned e;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            s = SUB_EN ? 1'($urandom) : 1'b0;
            e = model(8, a, b, c, s);
            run_d0(a, b, c, s, rs, rc, lat);
            checks++;
            if ({rc, rs} !== e[8:0] || lat != 8) begin
                errors++;
                $display("FAIL rand_d0: a=%h b=%h c=%b s=%b got %b_%h lat=%0d want %h lat 8",
                         a, b, c, s, rc, rs, lat, e[8:0]);
            end
        end
    endtask

    task automatic test_bpc4();
        logic [7:0] a, b, rs; logic c, rc; int lat; int unsigned e;
        run_d1(8'h37, 8'h48, 1'b0, 1'b0, rs, rc, lat);
        checks++;
        if ({rc, rs} !== 9'h07F || lat != 2) begin
            errors++;
            $display("FAIL bpc4_37_48: cout=%b sum=%h lat=%0d, want 0 7f 2", rc, rs, lat);
        end
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            e = model(8, a, b, c, 1'b0);
            run_d1(a, b, c, 1'b0, rs, rc, lat);
            checks++;
            if ({rc, rs} !== e[8:0] || lat != 2) begin
                errors++;
                $display("FAIL rand_d1: a=%h b=%h c=%b got %b_%h lat=%0d want %h lat 2",
                         a, b, c, rc, rs, lat, e[8:0]);
            end
        end
    endtask

    task automatic test_exhaustive_w4();
        logic [3:0] rs; logic rc; int lat; int unsigned e;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    e = model(4, ia, ib, ic[0], 1'b0);
                    run_d2(4'(ia), 4'(ib), ic[0], 1'b0, rs, rc, lat);
                    checks++;
                    if ({rc, rs} !== e[4:0] || lat != 1) begin
                        errors++;
                        $display("FAIL exh_w4: a=%h b=%h c=%0d got %b_%h lat=%0d want %h lat 1",
                                 ia, ib, ic, rc, rs, lat, e[4:0]);
                    end
                end
            end
        end
    endtask

    // out_ready and in_valid held high: one result every STEPS+2 = 4 cycles.
    task automatic test_back_to_back();
        logic [7:0] a, b; int done_cycles; int bad; int unsigned e;
        a = 8'($urandom); b = 8'($urandom);
        e = model(8, a, b, 1'b1, 1'b0);
        @(negedge clk);
        d1_a = a; d1_b = b; d1_cin = 1'b1; d1_sub = 1'b0;
        d1_in_valid = 1'b1; d1_out_ready = 1'b1;
        done_cycles = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d1_out_valid) begin
                done_cycles++;
                if ({d1_cout, d1_sum} !== e[8:0] || d1_in_ready) bad++;
            end
        end
        d1_in_valid = 1'b0;
        @(negedge clk);
        d1_out_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (done_cycles != 10 || bad != 0) begin
            errors++;
            $display("FAIL back_to_back: results=%0d bad=%0d, want 10 0", done_cycles, bad);
        end
    endtask

`ifdef BSA_SUB_EN
    task automatic test_sub();
        logic [7:0] rs; logic rc; int lat;
        run_d0(8'h10, 8'h01, 1'b0, 1'b1, rs, rc, lat);
        checks++;
        if ({rc, rs} !== 9'h10F) begin
            errors++;
            $display("FAIL sub_10_01: cout=%b sum=%h, want 1 0f", rc, rs);
        end
        run_d0(8'h01, 8'h02, 1'b0, 1'b1, rs, rc, lat);
        checks++;
        if ({rc, rs} !== 9'h0FF) begin
            errors++;
            $display("FAIL sub_01_02: cout=%b sum=%h, want 0 ff", rc, rs);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random_d0();
        test_bpc4();
        test_back_to_back();
        test_exhaustive_w4();
`ifdef BSA_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
